// File: rtl/mmio_console.sv
// mmio_console: memory-mapped byte console with a UART transmitter.
//
// A core store to CONSOLE_ADDR pushes the low byte of the store data into a
// small TX FIFO. A transmitter FSM drains the FIFO onto an 8N1 serial line
// (LSB first, idle high). A store to FINISH_ADDR records an end-of-test
// request; finish_req is raised only once every queued byte has left the line.
//
// Ports
//   clk         sole clock, all state on the rising edge
//   rst         synchronous active-high reset
//   dccm_wen    core store-write strobe
//   dccm_waddr  store address (full-width compare against the two addresses)
//   dccm_wdata  store data, only [7:0] is used
//   uart_tx     registered serial output
//   tx_busy     FSM not idle or FIFO holds bytes
//   fifo_full   FIFO holds FIFO_DEPTH bytes
//   drop_count  saturating count of bytes discarded on a full FIFO
//   finish_req  sticky end-of-test request, raised after the console drains
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for a byte in the FIFO
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP   | stop bit (high); pops the next byte directly when one waits

module mmio_console #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] CONSOLE_ADDR = 32'h0020_0000,
  parameter logic [XLEN-1:0] FINISH_ADDR  = 32'h1000_0000,
  parameter int unsigned     CLKS_PER_BIT = 868,
  parameter int unsigned     FIFO_DEPTH   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dccm_wen,
  input  logic [XLEN-1:0] dccm_waddr,
  input  logic [XLEN-1:0] dccm_wdata,
  output logic            uart_tx,
  output logic            tx_busy,
  output logic            fifo_full,
  output logic [15:0]     drop_count,
  output logic            finish_req
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and pointers
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // transmitter
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_bit_cnt;
  logic [CW-1:0] w_bit_cnt_nxt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;

  // status
  logic [15:0]   r_drop_count;
  logic          r_finish_seen;
  logic          r_finish_req;

  logic          w_console_wr;
  logic          w_finish_wr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_bit_done;
  logic          w_unused_wdata;

  assign w_unused_wdata = ^dccm_wdata[XLEN-1:8];

  assign w_console_wr = !rst && dccm_wen && (dccm_waddr == CONSOLE_ADDR);
  assign w_finish_wr  = dccm_wen && (dccm_waddr == FINISH_ADDR);
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FULL_CNT);
  assign w_bit_done   = (r_bit_cnt == '0);

  // A full FIFO still takes the byte when the transmitter pops on the same edge.
  assign w_push = w_console_wr && (!w_full || w_pop);

  // ---------------------------------------------------------------------------
  // Transmitter FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter FSM: next state and line value.
  // The line value follows the current state and is registered, so the start
  // bit appears one edge after the pop, two edges after the triggering store.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = 1'b1;
    w_pop         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = r_mem[r_rptr];
          w_bit_cnt_nxt = BIT_RELOAD;
          w_state_nxt   = S_START;
        end
      end

      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_done) begin
          w_bit_cnt_nxt = BIT_RELOAD;
          w_idx_nxt     = '0;
          w_state_nxt   = S_DATA;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - CW'(1);
        end
      end

      S_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_done) begin
          w_bit_cnt_nxt = BIT_RELOAD;
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - CW'(1);
        end
      end

      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_done) begin
          // Back-to-back frames: the next start bit begins on the edge the
          // stop bit ends, without passing through IDLE.
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = r_mem[r_rptr];
            w_bit_cnt_nxt = BIT_RELOAD;
            w_state_nxt   = S_START;
          end else begin
            w_state_nxt   = S_IDLE;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - CW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= dccm_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter and end-of-test handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_console_wr && !w_push && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // A store landing on the same edge keeps finish_req low: that byte is
  // still pending after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_finish_seen <= 1'b0;
      r_finish_req  <= 1'b0;
    end else begin
      r_finish_seen <= r_finish_seen | w_finish_wr;
      r_finish_req  <= r_finish_req |
                       (r_finish_seen && w_empty && (r_state == S_IDLE) && !w_push);
    end
  end

  assign uart_tx    = r_tx;
  assign tx_busy    = (r_state != S_IDLE) || !w_empty;
  assign fifo_full  = w_full;
  assign drop_count = r_drop_count;
  assign finish_req = r_finish_req;

endmodule

// File: tb/tb_mmio_console.sv
// Testbench for mmio_console (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// The reference model works on whole frames: a byte leaves the FIFO when the
// transmitter is free, and the line level at any edge is read off the frame
// timeline (start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT each).

module tb_mmio_console;

  localparam int C = 4;
  localparam int D = 4;
  localparam logic [31:0] CA = 32'h0020_0000;
  localparam logic [31:0] FA = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        dccm_wen;
  logic [31:0] dccm_waddr;
  logic [31:0] dccm_wdata;
  logic        uart_tx;
  logic        tx_busy;
  logic        fifo_full;
  logic [15:0] drop_count;
  logic        finish_req;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0] m_q [$];
  int         m_drops;
  bit         m_seen;
  bit         m_req;
  int         m_edge = 0;
  int         m_free_at;
  int         f_edge [$];
  logic [7:0] f_byte [$];

  mmio_console #(
    .XLEN         (32),
    .CONSOLE_ADDR (CA),
    .FINISH_ADDR  (FA),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dccm_wen   (dccm_wen),
    .dccm_waddr (dccm_waddr),
    .dccm_wdata (dccm_wdata),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .drop_count (drop_count),
    .finish_req (finish_req)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, m_edge);
    end
  endtask

  // Expected line level after edge t, from the list of popped frames.
  function automatic logic exp_tx(input int t);
    logic v;
    int   k;
    v = 1'b1;
    for (int i = 0; i < f_edge.size(); i++) begin
      if (t >= f_edge[i] + 1 && t < f_edge[i] + 1 + 10 * C) begin
        k = (t - f_edge[i] - 1) / C;
        if (k == 0)      v = 1'b0;
        else if (k == 9) v = 1'b1;
        else             v = f_byte[i][k-1];
      end
    end
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bit cw, fw, can_pop, push, new_req;
    m_edge++;
    while (f_edge.size() > 0 && f_edge[0] + 1 + 10 * C <= m_edge) begin
      void'(f_edge.pop_front());
      void'(f_byte.pop_front());
    end
    if (r) begin
      m_q.delete();
      f_edge.delete();
      f_byte.delete();
      m_drops   = 0;
      m_seen    = 0;
      m_req     = 0;
      m_free_at = m_edge;
      return;
    end
    cw      = w && (a == CA);
    fw      = w && (a == FA);
    can_pop = (m_q.size() > 0) && (m_edge >= m_free_at);
    push    = cw && ((m_q.size() < D) || can_pop);
    if (cw && !push && m_drops < 16'hFFFF) m_drops++;
    // finish_req rises only from a fully idle console with nothing arriving
    new_req = m_req || (m_seen && m_q.size() == 0 && m_free_at < m_edge && !push);
    if (can_pop) begin
      f_edge.push_back(m_edge);
      f_byte.push_back(m_q.pop_front());
      m_free_at = m_edge + 10 * C;
    end
    if (push) m_q.push_back(d[7:0]);
    if (fw) m_seen = 1;
    m_req = new_req;
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst        = r;
    dccm_wen   = w;
    dccm_waddr = a;
    dccm_wdata = d;
    @(posedge clk);
    model_edge(r, w, a, d);
    #1;
    check_val("uart_tx",    32'(uart_tx),    32'(exp_tx(m_edge)));
    check_val("tx_busy",    32'(tx_busy),    32'((m_q.size() > 0) || (m_edge < m_free_at)));
    check_val("fifo_full",  32'(fifo_full),  32'(m_q.size() == D));
    check_val("drop_count", 32'(drop_count), 32'(m_drops));
    check_val("finish_req", 32'(finish_req), 32'(m_req));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, a, {$urandom_range(0, 255) & 32'hFF, 8'h00} | 32'(d));
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b1, 1'b1, CA, 32'h5A);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int r;
    int dens;
    logic [31:0] a;

    rst = 1'b1; dccm_wen = 1'b0; dccm_waddr = '0; dccm_wdata = '0;
    do_reset(3);

    // single byte 0x41 from idle
    wr(CA, 8'h41);
    idle(45);

    // neighbouring addresses must not push
    wr(CA + 32'd1, 8'h11);
    wr(CA + 32'd4, 8'h22);
    wr(CA + 32'd2, 8'h33);
    wr(CA + 32'd3, 8'h44);
    idle(10);

    // six back-to-back stores into a 4-deep FIFO: one drop
    do_reset(1);
    for (int i = 0; i < 6; i++) wr(CA, 8'h30 + 8'(i));
    idle(6 * 10 * C);

    // full FIFO, store arrives on the edge the transmitter pops
    do_reset(1);
    for (int i = 0; i < 5; i++) wr(CA, 8'hA0 + 8'(i));
    guard = 0;
    while (m_edge + 1 != m_free_at && guard < 200) begin
      idle(1);
      guard++;
    end
    check_val("pop_edge_reached", 32'(guard < 200), 32'd1);
    wr(CA, 8'hC5);
    idle(7 * 10 * C);

    // reset in the middle of a frame with bytes queued
    do_reset(1);
    wr(CA, 8'h7E);
    wr(CA, 8'h01);
    wr(CA, 8'h02);
    idle(1 + 4 * C);
    do_reset(1);
    idle(3 * 10 * C);

    // randomized traffic
    do_reset(1);
    for (int blk = 0; blk < 30; blk++) begin
      dens = $urandom_range(2, 70);
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 399) == 0) begin
          do_reset(1);
        end else if ($urandom_range(0, 99) < dens) begin
          r = $urandom_range(0, 99);
          if (r < 70)      a = CA;
          else if (r < 78) a = CA + 32'($urandom_range(1, 3));
          else if (r < 82) a = CA + 32'd4;
          else if (r < 84) a = FA;
          else             a = $urandom;
          step(1'b0, 1'b1, a, $urandom);
        end else begin
          step(1'b0, 1'b0, $urandom, $urandom);
        end
      end
    end
    idle(6 * 10 * C);

    // end-of-test request must wait for the 0x55 frame to leave the line
    do_reset(1);
    wr(CA, 8'h55);
    step(1'b0, 1'b1, FA, 32'h0);
    idle(10 * C + 6);
    wr(CA, 8'h66);
    idle(12 * C);
    step(1'b0, 1'b1, FA, 32'h1);
    idle(10 * C);
    check_val("finish_sticky", 32'(finish_req), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
